// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg
//   Shared definitions for the single-port RAM burst controller:
//   RAM geometry constants and the controller state encoding.
package sp_ram_pkg;

    localparam int RAM_DW = 8;
    localparam int RAM_AW = 6;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CAP,
        RD_WAIT,
        DONE
    } sp_ram_ctrl_state_t;

endpackage

// File: rtl/sp_ram_burst_ctrl.sv
// sp_ram_burst_ctrl
//   Burst access controller for a 64x8 asynchronous single-port RAM.
//   Accepts a write or read command (start address, beats-1), then moves
//   one beat per address between valid/ready streams and the RAM.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write, cmd_addr, cmd_len   1=write burst; start address; beats-1
//   wr_valid/wr_ready, wr_data     write-data stream (into RAM)
//   rd_valid/rd_ready, rd_data     read-data stream (out of RAM)
//   rd_last                        marks final read beat
//   busy                           high in any state other than IDLE
//   done                           one-cycle pulse at burst completion
//   ram_data, ram_addr, ram_we     registered RAM control/data pins
//   ram_q                          combinational RAM read data
module sp_ram_burst_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
);

    sp_ram_ctrl_state_t r_state;
    sp_ram_ctrl_state_t w_state_next;

    logic [AW-1:0] r_cur_addr;
    logic [AW-1:0] r_remaining;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_data;
    logic          r_ram_we;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_rd_last;
    logic          r_done;

    logic w_cmd_hs;
    logic w_wr_hs;
    logic w_rd_hs;
    logic w_last_beat;

    assign w_cmd_hs    = cmd_valid & cmd_ready;
    assign w_wr_hs     = wr_valid & wr_ready;
    // rd_ready only counts while a beat is actually on offer
    assign w_rd_hs     = r_rd_valid & rd_ready;
    assign w_last_beat = (r_remaining == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_cmd_hs) begin
                    w_state_next = cmd_write ? WRITE : RD_ADDR;
                end
            end
            WRITE: begin
                if (w_wr_hs && w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            RD_ADDR: w_state_next = RD_CAP;
            RD_CAP:  w_state_next = RD_WAIT;
            RD_WAIT: begin
                if (w_rd_hs) begin
                    w_state_next = w_last_beat ? DONE : RD_ADDR;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready = (r_state == IDLE);
        wr_ready  = (r_state == WRITE);
        busy      = (r_state != IDLE);
    end

    // Counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_we    <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // A write strobe lives for exactly one cycle per accepted beat.
            r_ram_we <= 1'b0;
            // DONE lasts one cycle, so entering it is the whole pulse.
            r_done   <= (w_state_next == DONE);
            unique case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_cur_addr  <= cmd_addr;
                        r_remaining <= cmd_len;
                    end
                end
                WRITE: begin
                    if (w_wr_hs) begin
                        r_ram_addr  <= r_cur_addr;
                        r_ram_data  <= wr_data;
                        r_ram_we    <= 1'b1;
                        r_cur_addr  <= r_cur_addr + AW'(1);
                        r_remaining <= r_remaining - AW'(1);
                    end
                end
                RD_ADDR: begin
                    r_ram_addr <= r_cur_addr;
                end
                RD_CAP: begin
                    r_rd_data  <= ram_q;
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= w_last_beat;
                end
                RD_WAIT: begin
                    if (w_rd_hs) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        if (!w_last_beat) begin
                            r_cur_addr  <= r_cur_addr + AW'(1);
                            r_remaining <= r_remaining - AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign ram_we   = r_ram_we;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign done     = r_done;

endmodule

// File: tb/tb_sp_ram_burst_ctrl.sv
// tb_sp_ram_burst_ctrl
//   Self-checking bench for sp_ram_burst_ctrl. Contains a 64x8 RAM with
//   combinational read and clocked write as the controller's target, plus a
//   byte-array reference of what the RAM should hold. Directed scenarios are
//   followed by randomized bursts.
module tb_sp_ram_burst_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       done;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;

    logic [7:0] ram       [64];
    logic [7:0] model_mem [64];
    logic [7:0] wbuf      [64];

    int n_cmp = 0;
    int n_err = 0;

    sp_ram_burst_ctrl #(.DW(8), .AW(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .done      (done),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM target: combinational read, write on the clock edge while we=1
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_data;
    end
    assign ram_q = ram[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_we"}, ram_we, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    endtask

    // Write burst of len+1 beats from wbuf. mode 0: wr_valid held high,
    // 1: random wr_valid, 2: wr_valid pattern 1,0,0,1 repeating.
    // Called at a negedge with the controller idle.
    task automatic do_write(input int addr, input int len, input int mode);
        int         sent;
        int         k;
        bit         ev;
        bit         ed;
        bit         v;
        logic [5:0] ea;
        logic [7:0] edat;
        sent = 0; k = 0; ev = 0; ed = 0; ea = '0; edat = '0;
        chk("wr_cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 6'(addr);
        cmd_len   = 6'(len);
        wr_valid  = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            cmd_valid = 1'(($urandom_range(0, 1)));
            cmd_write = 1'(($urandom_range(0, 1)));
            cmd_addr  = 6'($urandom);
            chk("wr_we", ram_we, ev);
            if (ev) begin
                chk("wr_addr", ram_addr, ea);
                chk("wr_data", ram_data, edat);
            end
            chk("wr_done", done, ed);
            chk("wr_busy", busy, 1'b1);
            chk("wr_cmd_ready", cmd_ready, 1'b0);
            if (ed) break;
            chk("wr_ready", wr_ready, 1'b1);
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'(($urandom_range(0, 1)));
                default: v = (k % 4 == 0) || (k % 4 == 3);
            endcase
            k++;
            wr_valid = v;
            wr_data  = v ? wbuf[sent] : 8'($urandom);
            if (v) begin
                ea   = 6'(addr + sent);
                edat = wbuf[sent];
                model_mem[ea] = edat;
                sent++;
                ev = 1'b1;
                ed = (sent == len + 1);
            end else begin
                ev = 1'b0;
                ed = 1'b0;
            end
            @(negedge clk);
        end
        chk("wr_finished", ed, 1'b1);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        @(negedge clk);
        chk_idle("wr_after");
    endtask

    // Read burst of len+1 beats checked against model_mem. mode 0: rd_ready
    // always 1, 1: random, 2: first beat held off for 5 cycles.
    task automatic do_read(input int addr, input int len, input int mode);
        int got;
        int gap;
        int hold;
        bit fin;
        bit rr;
        got = 0; gap = 0; hold = 0; fin = 0;
        chk("rd_cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 6'(addr);
        cmd_len   = 6'(len);
        rd_ready  = 1'(($urandom_range(0, 1)));
        @(negedge clk);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            cmd_valid = 1'(($urandom_range(0, 1)));
            cmd_write = 1'(($urandom_range(0, 1)));
            wr_valid  = 1'(($urandom_range(0, 1)));
            wr_data   = 8'($urandom);
            chk("rd_we", ram_we, 1'b0);
            chk("rd_busy", busy, 1'b1);
            chk("rd_cmd_ready", cmd_ready, 1'b0);
            chk("rd_wr_ready", wr_ready, 1'b0);
            chk("rd_done", done, fin);
            if (fin) break;
            // each beat: two cycles without data, then data until taken
            chk("rd_valid", rd_valid, (gap == 2));
            if (gap == 2) begin
                chk("rd_data", rd_data, model_mem[6'(addr + got)]);
                chk("rd_last", rd_last, (got == len));
                case (mode)
                    0:       rr = 1'b1;
                    1:       rr = 1'(($urandom_range(0, 1)));
                    default: rr = (got != 0) || (hold >= 5);
                endcase
                rd_ready = rr;
                if (rr) begin
                    got++;
                    gap  = 0;
                    hold = 0;
                    fin  = (got == len + 1);
                end else begin
                    hold++;
                end
            end else begin
                rd_ready = 1'(($urandom_range(0, 1)));
                gap++;
            end
            @(negedge clk);
        end
        chk("rd_finished", fin, 1'b1);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        @(negedge clk);
        chk_idle("rd_after");
    endtask

    initial begin
        int a;
        int l;
        logic [7:0] d0;
        logic [7:0] d1;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_we", ram_we, 1'b0);
        chk("rst_addr", ram_addr, 6'd0);
        chk("rst_data", ram_data, 8'd0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'd0);
        chk("rst_rd_last", rd_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_wr_ready", wr_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 64-beat burst, data = address; also initializes the whole RAM
        for (int i = 0; i < 64; i++) wbuf[i] = 8'(i);
        do_write(0, 63, 0);
        do_read(0, 63, 0);

        // Single write then read
        wbuf[0] = 8'hAA;
        do_write(5, 0, 0);
        do_read(5, 0, 0);

        // Back-to-back burst
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_write(10, 3, 0);
        do_read(10, 3, 0);

        // Wrap-around
        wbuf[0] = 8'd1; wbuf[1] = 8'd2; wbuf[2] = 8'd3; wbuf[3] = 8'd4;
        do_write(62, 3, 0);
        do_read(0, 1, 0);
        do_read(62, 3, 1);

        // Backpressure on both directions
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(30, 3, 2);
        do_read(30, 3, 2);

        // Reset during the third beat of a 4-beat write
        d0 = 8'hC3;
        d1 = 8'h5A;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd20; cmd_len = 6'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_valid  = 1'b1; wr_data = d0;
        @(negedge clk);
        chk("mid_we0", ram_we, 1'b1);
        wr_data = d1;
        @(negedge clk);
        chk("mid_we1", ram_we, 1'b1);
        chk("mid_addr1", ram_addr, 6'd21);
        wr_data = ~model_mem[22];
        @(negedge clk);
        chk("mid_we2", ram_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 1'b0);
        chk("mid_rst_addr", ram_addr, 6'd0);
        chk("mid_rst_data", ram_data, 8'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_wr_ready", wr_ready, 1'b0);
        model_mem[20] = d0;
        model_mem[21] = d1;
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("mid_after");
        do_read(20, 2, 1);

        // Randomized bursts
        for (int t = 0; t < 8; t++) begin
            a = int'($urandom_range(0, 63));
            l = int'($urandom_range(0, 15));
            for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
            do_write(a, l, int'($urandom_range(0, 2)));
            do_read(int'($urandom_range(0, 63)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 2)));
        end
        do_read(0, 63, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_ram_burst_ctrl.md
Name: sp_ram_burst_ctrl

Overview:
Burst access controller that drives the data/addr/we/q port of the team's 64x8 asynchronous single-port RAM. It accepts a command (write or read, start address, length), then moves beats between valid/ready streams and the RAM, one address per beat. It sits between a bus-side master and the RAM macro, and owns every RAM control pin.

Parameters:
DW, 8, RAM data width
AW, 6, RAM address width; depth = 2**AW

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AW  start address
cmd_len  in  AW  beats minus one (0 -> 1 beat, 63 -> 64 beats)
wr_valid  in  1  write-data beat offered
wr_ready  out  1  write-data beat accepted
wr_data  in  DW  write-data beat
rd_valid  out  1  read-data beat available
rd_ready  in  1  read-data beat consumed
rd_data  out  DW  read-data beat
rd_last  out  1  qualifies final beat of read burst
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at burst completion
ram_data  out  DW  to RAM data
ram_addr  out  AW  to RAM addr
ram_we  out  1  to RAM we
ram_q  in  DW  from RAM q (combinational read)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All outputs are registered except cmd_ready, wr_ready and busy, which decode state.
- Reset values: state=IDLE, ram_we=0, ram_addr=0, ram_data=0, rd_valid=0, rd_data=0, rd_last=0, done=0. Reset mid-burst abandons the burst immediately; ram_we drops asynchronously. Beats already written stay in the RAM.
- States: IDLE, WRITE, RD_ADDR, RD_CAP, RD_WAIT, DONE.
- IDLE: cmd_ready=1. On a command handshake, latch cur_addr=cmd_addr and remaining=cmd_len. Go to WRITE if cmd_write=1, else RD_ADDR.
- WRITE: wr_ready=1. On a wr handshake at edge k, the registers load ram_addr=cur_addr, ram_data=wr_data, ram_we=1, so the write is presented during cycle k+1. Without a handshake, ram_we loads 0. This allows back-to-back writes at one beat per cycle. After each beat, cur_addr increments and remaining decrements. When the handshake has remaining==0, go to DONE.
- RD_ADDR: loads ram_addr=cur_addr and ram_we=0, then goes to RD_CAP. ram_we is 0 throughout a read burst.
- RD_CAP: loads rd_data=ram_q, rd_valid=1 and rd_last=(remaining==0), then goes to RD_WAIT.
- RD_WAIT: holds rd_data, rd_valid and rd_last stable until rd_ready. On the handshake, rd_valid and rd_last load 0. If remaining==0, go to DONE; otherwise increment cur_addr, decrement remaining and go to RD_ADDR.
- Read throughput: minimum 3 cycles per beat.
- DONE: done=1 for exactly one cycle and cmd_ready=0. For a write burst, this is the cycle in which the last beat has ram_we=1. At the DONE->IDLE edge, ram_we loads 0. A command may be accepted in the cycle after DONE.
- Address arithmetic: cur_addr wraps modulo 2**AW (63+1 -> 0). Bursts of 64 beats are legal and touch every address once.
- Inputs ignored outside their phase:
  - wr_valid is ignored outside WRITE and is never consumed there.
  - rd_ready is ignored unless rd_valid=1.
  - cmd_valid is ignored while busy.
- Backpressure: a write burst stalls indefinitely with wr_valid=0; ram_we=0 during stall cycles. A read burst stalls indefinitely with rd_ready=0.
- ram_we is never high for more than one cycle per accepted wr beat. ram_addr and ram_data only change on an edge.

Decomposition:
- Shared package sp_ram_pkg holds:
  - constants RAM_DW=8 and RAM_AW=6;
  - state typedef sp_ram_ctrl_state_t (IDLE, WRITE, RD_ADDR, RD_CAP, RD_WAIT, DONE).
- The async RAM model is reused unchanged as the bench target.
- No sub-module: the FSM, address/length counters and output registers form one flat block.

Test Plan:
- Single write then read: write cmd addr=5, len=0, data 0xAA; then read cmd addr=5, len=0. Expected: ram_we high one cycle with ram_addr=5 and ram_data=0xAA; done pulses; rd_data=0xAA with rd_last=1.
- Back-to-back write burst: addr=10, len=3, data 0x11,0x22,0x33,0x44 with wr_valid held high. Expected: ram_we high 4 consecutive cycles at addresses 10..13; done in the 4th. A read burst of the same range returns the same bytes in order, with rd_last only on 0x44.
- Wrap-around: write addr=62, len=3, data 1,2,3,4. Expected: writes land at 62, 63, 0, 1. A read at addr=0, len=1 returns 3, 4.
- Backpressure: wr_valid toggles 1,0,0,1 during a write, and rd_ready is held 0 for 5 cycles on a read. Expected: no ram_we during stall cycles; rd_data and rd_valid stable throughout the stall; cmd_ready=0 and busy=1 throughout.
- Reset mid-burst: assert rst_n=0 after 2 of 4 write beats. Expected: ram_we drops immediately and all outputs return to reset values. A read of the first 2 addresses returns the written data.
- Full 64-beat burst: write addr=0, len=63, data equal to address, then read back. Expected: all 64 bytes match; exactly one done per burst.
